// File: rtl/aes_block_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : aes_seq_pkg
// Description : Shared block geometry and sequencer state encoding for the
//               AES block sequencer.
// Revision    : 1.0  initial release
// ============================================================================
package aes_seq_pkg;

  localparam int BLK_BYTES = 16;
  localparam int BLK_BITS  = 128;

  typedef enum logic [2:0] {
    LOAD   = 3'd0,
    PAD    = 3'd1,
    GATHER = 3'd2,
    START  = 3'd3,
    WAIT   = 3'd4,
    EMIT   = 3'd5
  } seq_state_e;

endpackage
`default_nettype wire

// File: rtl/aes_block_sequencer_ram.sv
`default_nettype none
// ============================================================================
// Module      : seq_byte_ram
// Description : Byte-wide simple dual-port RAM, one write and one read port,
//               one cycle registered read. The array is not reset.
// Revision    : 1.0  initial release
// ============================================================================
module seq_byte_ram #(
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [7:0]    wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [7:0]    rdata_o
);

  logic [7:0] mem_q [DEPTH];
  logic [7:0] rdata_q;

  // Write port and registered read port
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/aes_block_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : aes_block_sequencer
// Description : Buffers a plaintext byte stream, zero-pads the tail block,
//               feeds 128-bit blocks to an external AES core (ECB or CBC)
//               and returns ciphertext on a valid/ready stream.
// Revision    : 1.0  initial release
// ============================================================================
module aes_block_sequencer
  import aes_seq_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_valid,
  input  logic [7:0]          wr_data,
  input  logic                wr_last,
  output logic                wr_ready,
  input  logic                cbc_en,
  input  logic [BLK_BITS-1:0] iv,
  output logic                core_start,
  output logic [BLK_BITS-1:0] core_block,
  input  logic                core_done,
  input  logic [BLK_BITS-1:0] core_result,
  output logic                ct_valid,
  output logic [BLK_BITS-1:0] ct_data,
  output logic                ct_last,
  input  logic                ct_ready,
  output logic                busy
);

  seq_state_e          state_q, state_d;
  logic [AW:0]         wr_ptr_q, rd_ptr_q;
  logic [4:0]          gcnt_q;
  logic                cbc_q;
  logic [BLK_BITS-1:0] chain_q, blk_q, core_block_q, ct_data_q;
  logic                ct_valid_q, ct_last_q;

  logic                wr_fire, last_byte, gather_done, more_blocks, ct_fire;
  logic [AW:0]         wr_ptr_inc, rd_ptr_nxt;
  logic [7:0]          rd_data;
  logic [BLK_BITS-1:0] blk_nxt;
  logic                ram_we;
  logic [7:0]          ram_wdata;
  logic [AW-1:0]       ram_raddr;

  // wr_ptr also serves as the end pointer once loading/padding is over,
  // since it does not move again until the message has drained.
  assign wr_fire     = wr_valid & wr_ready;
  assign wr_ptr_inc  = wr_ptr_q + 1'b1;
  assign last_byte   = wr_fire & (wr_last | (wr_ptr_inc == (AW+1)'(DEPTH)));
  assign gather_done = (gcnt_q == 5'd16);
  assign rd_ptr_nxt  = rd_ptr_q + (AW+1)'(BLK_BYTES);
  assign more_blocks = (rd_ptr_nxt != wr_ptr_q);
  assign ct_fire     = ct_valid_q & ct_ready;
  assign blk_nxt     = {blk_q[BLK_BITS-9:0], rd_data};

  assign ram_we    = wr_fire | (state_q == PAD);
  assign ram_wdata = (state_q == PAD) ? 8'h00 : wr_data;
  assign ram_raddr = rd_ptr_q[AW-1:0] + AW'(gcnt_q[3:0]);

  seq_byte_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .waddr_i (wr_ptr_q[AW-1:0]),
    .wdata_i (ram_wdata),
    .raddr_i (ram_raddr),
    .rdata_o (rd_data)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!rst) state_q <= LOAD;
    else      state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      LOAD:    if (last_byte) state_d = (wr_ptr_inc[3:0] != 4'd0) ? PAD : GATHER;
      PAD:     if (wr_ptr_inc[3:0] == 4'd0) state_d = GATHER;
      GATHER:  if (gather_done) state_d = START;
      START:   state_d = WAIT;
      WAIT:    if (core_done) state_d = EMIT;
      EMIT:    if (ct_fire) state_d = more_blocks ? GATHER : LOAD;
      default: state_d = LOAD;
    endcase
  end

  // Handshake outputs decoded from state
  always_comb begin
    wr_ready   = (state_q == LOAD);
    core_start = (state_q == START);
    busy       = !((state_q == LOAD) && (wr_ptr_q == '0));
  end

  // Datapath: pointers, block assembly, chaining and output registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      gcnt_q       <= '0;
      cbc_q        <= 1'b0;
      chain_q      <= '0;
      blk_q        <= '0;
      core_block_q <= '0;
      ct_data_q    <= '0;
      ct_valid_q   <= 1'b0;
      ct_last_q    <= 1'b0;
    end else begin
      unique case (state_q)
        LOAD: begin
          if (wr_fire) begin
            wr_ptr_q <= wr_ptr_inc;
            if (wr_ptr_q == '0) begin
              cbc_q   <= cbc_en;
              chain_q <= iv;
            end
          end
        end
        PAD: wr_ptr_q <= wr_ptr_inc;
        GATHER: begin
          // Cycle 0 only issues the first read; bytes land one cycle later.
          gcnt_q <= gather_done ? 5'd0 : gcnt_q + 5'd1;
          if (gcnt_q != 5'd0) blk_q <= blk_nxt;
          if (gather_done) core_block_q <= blk_nxt ^ (cbc_q ? chain_q : '0);
        end
        WAIT: begin
          if (core_done) begin
            ct_valid_q <= 1'b1;
            ct_data_q  <= core_result;
            ct_last_q  <= !more_blocks;
          end
        end
        EMIT: begin
          if (ct_fire) begin
            ct_valid_q <= 1'b0;
            chain_q    <= ct_data_q;
            if (more_blocks) begin
              rd_ptr_q <= rd_ptr_nxt;
            end else begin
              rd_ptr_q <= '0;
              wr_ptr_q <= '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign core_block = core_block_q;
  assign ct_valid   = ct_valid_q;
  assign ct_data    = ct_data_q;
  assign ct_last    = ct_last_q;

endmodule
`default_nettype wire
